// File: rtl/rsa_arb_pkg.sv
// Shared constants for the RSA core arbiter: core command codes, FSM encoding, default watchdog.
// Latency: n/a (package only).
// Backpressure: n/a.
package rsa_arb_pkg;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_ENC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;

  localparam int DEFAULT_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  function automatic logic cmd_is_op(input logic [1:0] cmd);
    return (cmd == CMD_ENC) || (cmd == CMD_DEC);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority grant: first requester after ptr (mod N_REQ) wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    gnt_idx,
  output logic             gnt_any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!gnt_any && req[idx]) begin
        gnt_any      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rsa_core_arbiter.sv
// Shares one mod_exp core among N_REQ requesters, round-robin, one operation at a time.
// Latency: core_cmd one cycle after accept; rsp_valid one cycle after p_sync (or timeout/invalid).
// Backpressure: req_ready only in IDLE; requesters hold valid+operands until accepted.
module rsa_core_arbiter
  import rsa_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int W       = 65,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [2*N_REQ-1:0]       req_cmd,
  input  logic [W*N_REQ-1:0]       req_msg,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic                     rsp_err,
  output logic [W-1:0]             rsp_data,
  output logic [W-1:0]             core_msg,
  output logic [1:0]               core_cmd,
  input  logic [W-1:0]             core_p_msg,
  input  logic                     core_p_sync,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner
);

  localparam int OW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);

  arb_state_t       state, state_nxt;
  logic [OW-1:0]    rr_ptr;
  logic [OW-1:0]    gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic             gnt_any;
  logic [1:0]       sel_cmd;
  logic [W-1:0]     sel_msg;
  logic [TW-1:0]    timer;
  logic             accept;
  logic             timed_out;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_cmd = CMD_IDLE;
    sel_msg = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_cmd = req_cmd[2*i +: 2];
        sel_msg = req_msg[W*i +: W];
      end
    end
  end

  assign accept    = (state == ST_IDLE) && gnt_any;
  assign timed_out = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = cmd_is_op(sel_cmd) ? ST_BUSY : ST_RESP;
      ST_BUSY: if (core_p_sync || timed_out) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // req_ready is forced low during reset even though state already reads IDLE.
  always_comb begin
    req_ready = (state == ST_IDLE && rst_n) ? gnt : '0;
    busy      = (state != ST_IDLE);
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = (state == ST_RESP) && (owner == OW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= OW'(N_REQ - 1);
      owner    <= '0;
      core_cmd <= CMD_IDLE;
      core_msg <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      timer    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner  <= gnt_idx;
            rr_ptr <= gnt_idx;
            if (cmd_is_op(sel_cmd)) begin
              core_cmd <= sel_cmd;
              core_msg <= sel_msg;
              timer    <= '0;
            end else begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
            end
          end
        end
        ST_BUSY: begin
          timer <= timer + 1'b1;
          // A completion on the final watchdog cycle still counts as success.
          if (core_p_sync) begin
            rsp_data <= core_p_msg;
            rsp_err  <= 1'b0;
            core_cmd <= CMD_IDLE;
          end else if (timed_out) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            core_cmd <= CMD_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Self-checking bench for rsa_core_arbiter: directed table, corner sequences, randomized ops vs. a transaction model.
module tb_rsa_core_arbiter;

  localparam int N  = 3;
  localparam int W  = 65;
  localparam int TO = 16;
  localparam int OW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [2*N-1:0]   req_cmd = '0;
  logic [W*N-1:0]   req_msg = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     rsp_valid;
  logic             rsp_err;
  logic [W-1:0]     rsp_data;
  logic [W-1:0]     core_msg;
  logic [1:0]       core_cmd;
  logic [W-1:0]     core_p_msg = '0;
  logic             core_p_sync = 1'b0;
  logic             busy;
  logic [OW-1:0]    owner;

  rsa_core_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_msg(req_msg), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .core_msg(core_msg), .core_cmd(core_cmd), .core_p_msg(core_p_msg), .core_p_sync(core_p_sync),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Requester-side state and per-requester stub-core behaviour.
  bit           pend_v[N];
  logic [1:0]   pend_cmd[N];
  logic [W-1:0] pend_msg[N];
  int           req_lat[N];
  logic [W-1:0] req_pdata[N];
  bit           stray_sync = 1'b0;
  logic [W-1:0] stray_data = 65'h1_5A5A_5A5A_5A5A_5A5A;
  int           stub_cnt = 0;
  int           n_chk = 0;
  int           n_pass = 0;
  int           last_g = N - 1;

  // Stub core: answers once it has seen a non-idle cmd for req_lat cycles (0 = never answers).
  always @(negedge clk) begin
    if (!rst_n || core_cmd == 2'b00) stub_cnt = 0;
    else                             stub_cnt = stub_cnt + 1;
    core_p_sync = stray_sync ||
                  (core_cmd != 2'b00 && req_lat[owner] != 0 && stub_cnt == req_lat[owner]);
    core_p_msg  = stray_sync ? stray_data : req_pdata[owner];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend_v[i];
      req_cmd[2*i +: 2]  = pend_cmd[i];
      req_msg[W*i +: W]  = pend_msg[i];
    end
  endtask

  // One cycle: drive just after the rising edge, leave room to sample afterwards.
  task automatic step();
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask

  function automatic int rr_expect();
    for (int k = 1; k <= N; k++) begin
      if (pend_v[(last_g + k) % N]) return (last_g + k) % N;
    end
    return -1;
  endfunction

  // Transaction-level model of the response for one operation.
  task automatic model(input logic [1:0] cmd, input int lat, input logic [W-1:0] pd,
                       output int e, output logic [W-1:0] d, output int l, output int c);
    if (cmd != 2'b01 && cmd != 2'b10) begin
      e = 1; d = '0; l = 1; c = 0;
    end else if (lat != 0 && lat <= TO) begin
      e = 0; d = pd; l = lat + 1; c = lat;
    end else begin
      e = 1; d = '0; l = TO + 1; c = TO;
    end
  endtask

  task automatic wait_accept(output int g);
    logic [N-1:0] acc;
    int eg;
    g  = -1;
    eg = rr_expect();
    for (int c = 0; c < 40; c++) begin
      step();
      if (c == 0) chk("idle_core_cmd", int'(core_cmd), 0);
      acc = req_valid & req_ready;
      if (acc != '0) begin
        for (int i = N - 1; i >= 0; i--) if (acc[i]) g = i;
        chk("ready_onehot", $countones(req_ready), 1);
        chk("grant", g, eg);
        last_g = eg;
        break;
      end
    end
    if (g < 0) chk("accept_within_budget", 0, 1);
  endtask

  task automatic finish_op(input int g, input int e_err, input logic [W-1:0] e_data,
                           input int e_lat, input int e_cyc);
    logic [1:0]   cmd;
    logic [W-1:0] msg;
    int           cyc, lat;
    bit           held_ok;
    cmd = pend_cmd[g]; msg = pend_msg[g];
    cyc = 0; lat = 0; held_ok = 1'b1;
    pend_v[g] = 1'b0;
    for (int k = 1; k <= TO + 30; k++) begin
      step();
      if (rsp_valid != '0) begin lat = k; break; end
      if (core_cmd != 2'b00) begin
        cyc++;
        if (core_cmd !== cmd || core_msg !== msg) held_ok = 1'b0;
      end
      if (!busy) held_ok = 1'b0;
    end
    if (lat == 0) chk("rsp_within_budget", 0, 1);
    else begin
      chk("rsp_owner", int'(rsp_valid), 1 << g);
      chk("rsp_err", int'(rsp_err), e_err);
      chkw("rsp_data", rsp_data, e_data);
      chk("rsp_latency", lat, e_lat);
      chk("cmd_cycles", cyc, e_cyc);
      chk("cmd_msg_held_busy", int'(held_ok), 1);
      chk("cmd_idle_in_resp", int'(core_cmd), 0);
      if (e_cyc > 0) chkw("core_msg_retained", core_msg, msg);
    end
  endtask

  task automatic new_req(input int i);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      pend_cmd[i] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    else if (r < 5)  pend_cmd[i] = 2'b01;
    else             pend_cmd[i] = 2'b10;
    pend_msg[i]  = W'({$urandom, $urandom, $urandom});
    req_pdata[i] = W'({$urandom, $urandom, $urandom});
    req_lat[i]   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
    pend_v[i]    = 1'b1;
  endtask

  typedef struct {
    int         r;
    logic [1:0] cmd;
    logic [W-1:0] msg;
    int         lat;
    logic [W-1:0] pd;
    int         e_err;
    logic [W-1:0] e_data;
    int         e_lat;
    int         e_cyc;
  } vec_t;

  vec_t tbl[8];
  int   exp_seq[4];

  initial begin
    int g, e, l, c;
    logic [W-1:0] d;
    bit ok;

    tbl[0] = '{0, 2'b01, 65'h1234,              10, 65'hABCD,             0, 65'hABCD,             11, 10};
    tbl[1] = '{1, 2'b11, 65'h1_0000_0000_0000_0077, 5, 65'h55,            1, 65'h0,                 1,  0};
    tbl[2] = '{2, 2'b10, 65'h1_DEAD_BEEF_0000_0001, 3, 65'h0_0BAD_F00D,   0, 65'h0_0BAD_F00D,       4,  3};
    tbl[3] = '{0, 2'b00, 65'h42,                 4, 65'h99,               1, 65'h0,                 1,  0};
    tbl[4] = '{1, 2'b01, 65'h777,                1, 65'h1_FFFF_FFFF_FFFF_FFFF, 0, 65'h1_FFFF_FFFF_FFFF_FFFF, 2, 1};
    tbl[5] = '{0, 2'b10, 65'h3131,              16, 65'hC0FFEE,            0, 65'hC0FFEE,           17, 16};
    tbl[6] = '{2, 2'b01, 65'h2222,              17, 65'h1111,              1, 65'h0,                17, 16};
    tbl[7] = '{1, 2'b01, 65'h5151,               0, 65'h1111,              1, 65'h0,                17, 16};
    exp_seq = '{0, 1, 0, 1};

    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b1; pend_cmd[i] = 2'b01; pend_msg[i] = W'(i + 1);
      req_lat[i] = 0; req_pdata[i] = '0;
    end

    // Reset state, with every requester asking.
    step(); step();
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_core_cmd", int'(core_cmd), 0);
    chkw("reset_core_msg", core_msg, '0);
    chkw("reset_rsp_data", rsp_data, '0);
    chk("reset_rsp_err", int'(rsp_err), 0);
    chk("reset_owner", int'(owner), 0);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    drive();
    rst_n = 1'b1;
    last_g = N - 1;

    // Directed table, one request at a time.
    for (int t = 0; t < 8; t++) begin
      pend_cmd[tbl[t].r]  = tbl[t].cmd;
      pend_msg[tbl[t].r]  = tbl[t].msg;
      req_lat[tbl[t].r]   = tbl[t].lat;
      req_pdata[tbl[t].r] = tbl[t].pd;
      pend_v[tbl[t].r]    = 1'b1;
      wait_accept(g);
      if (g >= 0) finish_op(g, tbl[t].e_err, tbl[t].e_data, tbl[t].e_lat, tbl[t].e_cyc);
      else pend_v[tbl[t].r] = 1'b0;
    end

    // Stray p_sync after the timed-out operation must be ignored.
    ok = 1'b1;
    stray_sync = 1'b1;
    step(); step();
    stray_sync = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (busy || rsp_valid != '0 || rsp_data !== '0) ok = 1'b0;
      step();
    end
    chk("stray_psync_ignored", int'(ok), 1);

    // Next request after the timeout is served normally.
    pend_cmd[2] = 2'b10; pend_msg[2] = 65'h9876; req_lat[2] = 6; req_pdata[2] = 65'h1_2345;
    pend_v[2] = 1'b1;
    wait_accept(g);
    if (g >= 0) finish_op(g, 0, 65'h1_2345, 7, 6);
    else pend_v[2] = 1'b0;

    // Reset during cycle 5 of a busy operation.
    pend_cmd[0] = 2'b01; pend_msg[0] = 65'hAAAA; req_lat[0] = 0; pend_v[0] = 1'b1;
    wait_accept(g);
    pend_v[0] = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    chk("midop_busy_before_reset", int'(busy), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    pend_v[0] = 1'b1; pend_v[1] = 1'b1; pend_cmd[1] = 2'b10;
    drive();
    #1;
    chk("midop_reset_busy", int'(busy), 0);
    chk("midop_reset_core_cmd", int'(core_cmd), 0);
    chkw("midop_reset_core_msg", core_msg, '0);
    chk("midop_reset_rsp_valid", int'(rsp_valid), 0);
    chk("midop_reset_owner", int'(owner), 0);
    chk("midop_reset_req_ready", int'(req_ready), 0);
    chkw("midop_reset_rsp_data", rsp_data, '0);
    step();
    @(posedge clk); #1;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    drive();
    rst_n = 1'b1;
    #1;
    chk("post_reset_no_rsp", int'(rsp_valid), 0);
    last_g = N - 1;

    // Contention: req0 and req1 both valid for four operations.
    for (int i = 0; i < 2; i++) begin
      pend_cmd[i] = (i == 0) ? 2'b01 : 2'b10;
      pend_msg[i] = W'(65'h100 + i); req_lat[i] = 3 + i; req_pdata[i] = W'(65'h500 + i);
      pend_v[i] = 1'b1;
    end
    for (int n = 0; n < 4; n++) begin
      wait_accept(g);
      chk("contention_order", g, exp_seq[n]);
      if (g < 0) break;
      model(pend_cmd[g], req_lat[g], req_pdata[g], e, d, l, c);
      finish_op(g, e, d, l, c);
      pend_msg[g] = W'({$urandom, $urandom, $urandom});
      req_pdata[g] = W'({$urandom, $urandom, $urandom});
      req_lat[g] = $urandom_range(1, 8);
      pend_v[g] = 1'b1;
    end
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;

    // Randomized traffic against the transaction model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) if (!pend_v[i] && $urandom_range(0, 1) == 1) new_req(i);
      if (!(pend_v[0] || pend_v[1] || pend_v[2])) new_req($urandom_range(0, N - 1));
      wait_accept(g);
      if (g < 0) break;
      model(pend_cmd[g], req_lat[g], req_pdata[g], e, d, l, c);
      finish_op(g, e, d, l, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
